// File: rtl/move_scheduler_pkg.sv
// Direction codes, reversal helper and scheduler state encoding shared with the game-state controller.
// Pure definitions: no latency, no backpressure.
package move_scheduler_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    REQ       = 2'd2,
    OVER      = 2'd3
  } sched_state_t;

  localparam int PERIOD_W = 32;

  function automatic logic [2:0] opposite_dir(input logic [2:0] d);
    case (d)
      DIR_UP:    opposite_dir = DIR_DOWN;
      DIR_DOWN:  opposite_dir = DIR_UP;
      DIR_LEFT:  opposite_dir = DIR_RIGHT;
      DIR_RIGHT: opposite_dir = DIR_LEFT;
      default:   opposite_dir = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Controller/core-facing signals of the move scheduler; master = scheduler, slave = controller and core.
// Step handshake: step_req holds until step_ack, so the core may stall indefinitely.
interface move_scheduler_if #(
  parameter int XW = 6,
  parameter int YW = 5
);
  logic [2:0]    dir;
  logic          game_run;
  logic          game_reset_pulse;
  logic          step_ack;
  logic          hit_self;
  logic          step_req;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [2:0]    cur_dir;
  logic          game_over;
  logic [15:0]   move_count;

  modport master (
    input  dir, game_run, game_reset_pulse, step_ack, hit_self,
    output step_req, head_x, head_y, cur_dir, game_over, move_count
  );

  modport slave (
    output dir, game_run, game_reset_pulse, step_ack, hit_self,
    input  step_req, head_x, head_y, cur_dir, game_over, move_count
  );
endinterface

// File: rtl/move_tick_counter.sv
// Move-tick counter: tick is a combinational 1-clk pulse in the cycle the count reaches period-1.
// Holds while enable is low (pause); clear forces the count back to 0.
module move_tick_counter
  import move_scheduler_pkg::*;
#(
  parameter int PW = PERIOD_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  input  logic [PW-1:0] period,
  output logic          tick
);
  logic [PW-1:0] cnt;

  // >= keeps the counter safe if the period ever shrinks below the running count
  assign tick = enable && !clear && (cnt >= period - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/move_scheduler.sv
// Snake move scheduler: one head step per tick, step_req/step_ack handshake, wall/self collision; step_req
// rises on the edge ending the period-th counted cycle and holds until step_ack. MOVE_SPEEDUP_EN shortens the period.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int XW       = 6,
  parameter int YW       = 5,
  parameter int TICK_DIV = 12500000,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input logic             clk,
  input logic             rst,
  move_scheduler_if.master bus
);
  localparam logic [XW-1:0]       X0          = XW'(START_X);
  localparam logic [YW-1:0]       Y0          = YW'(START_Y);
  localparam logic [XW-1:0]       X_MAX       = XW'(GRID_W - 1);
  localparam logic [YW-1:0]       Y_MAX       = YW'(GRID_H - 1);
  localparam logic [PERIOD_W-1:0] BASE_PERIOD = PERIOD_W'(TICK_DIV);

  sched_state_t        state;
  logic                step_req, game_over;
  logic [XW-1:0]       head_x, nxt_x;
  logic [YW-1:0]       head_y, nxt_y;
  logic [2:0]          cur_dir, eff_dir;
  logic [15:0]         move_count;
  logic [PERIOD_W-1:0] period;
  logic                tick, wall, dir_ok;

  move_tick_counter #(.PW(PERIOD_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (state == WAIT_TICK && bus.game_run),
    .clear  (bus.game_reset_pulse || state != WAIT_TICK),
    .period (period),
    .tick   (tick)
  );

  // Bounds are tested before the +/-1 so an out-of-grid head never forms.
  always_comb begin
    dir_ok  = (bus.dir != DIR_NONE) && (bus.dir <= DIR_RIGHT) &&
              (cur_dir == DIR_NONE || bus.dir != opposite_dir(cur_dir));
    eff_dir = dir_ok ? bus.dir : cur_dir;
    nxt_x   = head_x;
    nxt_y   = head_y;
    wall    = 1'b0;
    case (eff_dir)
      DIR_UP:    if (head_y == '0)    wall = 1'b1; else nxt_y = head_y - 1'b1;
      DIR_DOWN:  if (head_y == Y_MAX) wall = 1'b1; else nxt_y = head_y + 1'b1;
      DIR_LEFT:  if (head_x == '0)    wall = 1'b1; else nxt_x = head_x - 1'b1;
      DIR_RIGHT: if (head_x == X_MAX) wall = 1'b1; else nxt_x = head_x + 1'b1;
      default: ;
    endcase
  end

`ifdef MOVE_SPEEDUP_EN
  localparam logic [PERIOD_W-1:0] STEP_DEC   = PERIOD_W'(TICK_DIV / 16);
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(TICK_DIV / 4);

  // The 8th, 16th, ... completed step shortens the tick period down to the floor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      period <= BASE_PERIOD;
    else if (bus.game_reset_pulse)
      period <= BASE_PERIOD;
    else if (state == REQ && bus.step_ack && move_count[2:0] == 3'd7 && move_count != 16'hFFFF)
      period <= (period - MIN_PERIOD >= STEP_DEC) ? period - STEP_DEC : MIN_PERIOD;
  end
`else
  assign period = BASE_PERIOD;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; head_x <= X0; head_y <= Y0; cur_dir <= DIR_NONE;
      step_req <= 1'b0; game_over <= 1'b0; move_count <= '0;
    end else if (bus.game_reset_pulse) begin
      state <= IDLE; head_x <= X0; head_y <= Y0; cur_dir <= DIR_NONE;
      step_req <= 1'b0; game_over <= 1'b0; move_count <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.game_run && bus.dir != DIR_NONE) state <= WAIT_TICK;
        WAIT_TICK:
          if (tick && eff_dir != DIR_NONE) begin
            if (wall) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              head_x   <= nxt_x;
              head_y   <= nxt_y;
              cur_dir  <= eff_dir;
              step_req <= 1'b1;
              state    <= REQ;
            end
          end
        REQ:
          if (bus.step_ack) begin
            step_req <= 1'b0;
            if (move_count != 16'hFFFF) move_count <= move_count + 1'b1;
            if (bus.hit_self) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= WAIT_TICK;
            end
          end
        default: ;
      endcase
    end
  end

  assign bus.step_req   = step_req;
  assign bus.head_x     = head_x;
  assign bus.head_y     = head_y;
  assign bus.cur_dir    = cur_dir;
  assign bus.game_over  = game_over;
  assign bus.move_count = move_count;
endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed scenarios plus random traffic, compared every cycle
// against a behavioural model of the movement rules.
module tb_move_scheduler;
  localparam int GW = 40, GH = 30, TD = 4, SX = 20, SY = 15;
  localparam int PH_STOPPED = 0, PH_TIMING = 1, PH_STEPPING = 2, PH_DEAD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;

  move_scheduler_if #(.XW(6), .YW(5)) bus ();

  move_scheduler #(
    .GRID_W(GW), .GRID_H(GH), .XW(6), .YW(5),
    .TICK_DIV(TD), .START_X(SX), .START_Y(SY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int m_ph, m_cnt, m_x, m_y, m_dir, m_moves;
  bit m_req, m_over;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input int dut_v, input int mdl_v, input int exp);
    chk(name, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  function automatic bit reverses(input int a, input int b);
    return (a == 1 && b == 2) || (a == 2 && b == 1) || (a == 3 && b == 4) || (a == 4 && b == 3);
  endfunction

  task automatic model_reset();
    m_ph = PH_STOPPED; m_cnt = 0; m_x = SX; m_y = SY; m_dir = 0;
    m_moves = 0; m_req = 0; m_over = 0;
  endtask

  // Movement rules: one step per TD running cycles, walls end the game, acks count steps.
  always @(posedge clk or posedge rst) begin : model
    int d, nx, ny, req_dir;
    if (rst || bus.game_reset_pulse) model_reset();
    else begin
      req_dir = int'(bus.dir);
      case (m_ph)
        PH_STOPPED:
          if (bus.game_run && req_dir != 0) begin m_ph = PH_TIMING; m_cnt = 0; end
        PH_TIMING:
          if (bus.game_run) begin
            m_cnt++;
            if (m_cnt == TD) begin
              m_cnt = 0;
              d = (req_dir != 0 && !(m_dir != 0 && reverses(req_dir, m_dir))) ? req_dir : m_dir;
              nx = m_x; ny = m_y;
              case (d)
                1: ny = m_y - 1;
                2: ny = m_y + 1;
                3: nx = m_x - 1;
                4: nx = m_x + 1;
                default: ;
              endcase
              if (d != 0) begin
                if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                  m_ph = PH_DEAD; m_over = 1;
                end else begin
                  m_x = nx; m_y = ny; m_dir = d; m_req = 1; m_ph = PH_STEPPING;
                end
              end
            end
          end
        PH_STEPPING:
          if (bus.step_ack) begin
            m_req = 0;
            if (m_moves < 65535) m_moves++;
            if (bus.hit_self) begin m_ph = PH_DEAD; m_over = 1; end
            else m_ph = PH_TIMING;
          end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("step_req",   int'(bus.step_req),   int'(m_req));
      chk("head_x",     int'(bus.head_x),     m_x);
      chk("head_y",     int'(bus.head_y),     m_y);
      chk("cur_dir",    int'(bus.cur_dir),    m_dir);
      chk("game_over",  int'(bus.game_over),  int'(m_over));
      chk("move_count", int'(bus.move_count), m_moves);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input int max_cyc, output int n);
    n = 0;
    while (!bus.step_req && n < max_cyc) begin
      step();
      n++;
    end
    if (!bus.step_req) chk("req_timeout", int'(bus.step_req), 1);
  endtask

  task automatic ack(input bit hs);
    bus.step_ack = 1'b1;
    bus.hit_self = hs;
    step();
    bus.step_ack = 1'b0;
    bus.hit_self = 1'b0;
  endtask

  task automatic game_reset();
    bus.game_reset_pulse = 1'b1;
    step();
    bus.game_reset_pulse = 1'b0;
  endtask

  initial begin
    int n;
    bus.dir = 3'd0; bus.game_run = 1'b0; bus.game_reset_pulse = 1'b0;
    bus.step_ack = 1'b0; bus.hit_self = 1'b0;
    step(); step();
    pin("rst_head_x", int'(bus.head_x), m_x, SX);
    pin("rst_head_y", int'(bus.head_y), m_y, SY);
    pin("rst_step_req", int'(bus.step_req), int'(m_req), 0);
    pin("rst_game_over", int'(bus.game_over), int'(m_over), 0);
    pin("rst_cur_dir", int'(bus.cur_dir), m_dir, 0);
    pin("rst_move_count", int'(bus.move_count), m_moves, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // basic move right: one IDLE cycle, then TD counted cycles
    bus.game_run = 1'b1; bus.dir = 3'd4;
    wait_req(20, n);
    chk("first_latency", n, 5);
    pin("move1_x", int'(bus.head_x), m_x, 21);
    pin("move1_dir", int'(bus.cur_dir), m_dir, 4);
    ack(1'b0);
    pin("ack1_req", int'(bus.step_req), int'(m_req), 0);
    pin("ack1_count", int'(bus.move_count), m_moves, 1);
    wait_req(20, n);
    chk("second_latency", n, 4);
    pin("move2_x", int'(bus.head_x), m_x, 22);

    // reversal is ignored, a perpendicular turn is taken
    bus.dir = 3'd3; ack(1'b0);
    wait_req(20, n);
    pin("rev_x", int'(bus.head_x), m_x, 23);
    pin("rev_dir", int'(bus.cur_dir), m_dir, 4);
    bus.dir = 3'd1; ack(1'b0);
    wait_req(20, n);
    pin("up_y", int'(bus.head_y), m_y, 14);
    pin("up_x", int'(bus.head_x), m_x, 23);

    // pause at count 2, then a paused REQ
    ack(1'b0); step(); step();
    bus.game_run = 1'b0;
    repeat (10) step();
    pin("pause_req", int'(bus.step_req), int'(m_req), 0);
    bus.game_run = 1'b1;
    wait_req(20, n);
    chk("resume_latency", n, 2);
    pin("resume_y", int'(bus.head_y), m_y, 13);
    bus.game_run = 1'b0;
    repeat (5) step();
    pin("req_hold", int'(bus.step_req), int'(m_req), 1);
    ack(1'b0);
    pin("paused_ack_count", int'(bus.move_count), m_moves, 5);
    pin("paused_ack_req", int'(bus.step_req), int'(m_req), 0);
    bus.game_run = 1'b1;

    // game reset in the middle of a handshake
    wait_req(20, n);
    game_reset();
    pin("midreset_req", int'(bus.step_req), int'(m_req), 0);
    pin("midreset_x", int'(bus.head_x), m_x, SX);
    pin("midreset_y", int'(bus.head_y), m_y, SY);
    pin("midreset_count", int'(bus.move_count), m_moves, 0);

    // self hit
    bus.dir = 3'd2;
    wait_req(20, n);
    chk("restart_latency", n, 5);
    pin("down_y", int'(bus.head_y), m_y, 16);
    ack(1'b1);
    pin("selfhit_over", int'(bus.game_over), int'(m_over), 1);
    pin("selfhit_req", int'(bus.step_req), int'(m_req), 0);
    repeat (8) step();
    pin("over_frozen_y", int'(bus.head_y), m_y, 16);
    pin("over_count", int'(bus.move_count), m_moves, 1);

    // right wall after 19 steps from column 20
    game_reset();
    bus.dir = 3'd4;
    for (int i = 0; i < 19; i++) begin
      wait_req(20, n);
      ack(1'b0);
    end
    repeat (8) step();
    pin("wall_over", int'(bus.game_over), int'(m_over), 1);
    pin("wall_x", int'(bus.head_x), m_x, 39);
    pin("wall_req", int'(bus.step_req), int'(m_req), 0);
    pin("wall_count", int'(bus.move_count), m_moves, 19);
    game_reset();
    pin("wall_reset_x", int'(bus.head_x), m_x, SX);
    pin("wall_reset_over", int'(bus.game_over), int'(m_over), 0);

    // random traffic, including one asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      bus.game_run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) bus.dir = 3'($urandom_range(0, 4));
      bus.step_ack = ($urandom_range(0, 2) == 0);
      bus.hit_self = bus.step_ack && ($urandom_range(0, 15) == 0);
      bus.game_reset_pulse = ($urandom_range(0, 299) == 0) ||
                             (bus.game_over && $urandom_range(0, 19) == 0);
      if (i == 1500) rst = 1'b1;
      if (i == 1503) rst = 1'b0;
      step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
